sub_nbit_cia_seq: RTL and testbench

Multi-cycle N-bit subtractor computing a − b − bin one CHUNK-bit slice per clock, LSB slice first. The borrow chains between slices through a registered carry. It is the subtracting counterpart to the team's carry-increment adders, sized for wide operands where a full-width carry chain would miss timing. Operands arrive and results leave on valid/ready handshakes.

---
 rtl/sub_cia_pkg.sv | 25 ++
 rtl/chunk_sub_cia.sv | 20 ++
 rtl/sub_nbit_cia_seq.sv | 123 ++++++++++++
 tb/tb_sub_nbit_cia_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_cia_pkg.sv
// Shared types and sizing helpers for the sliced carry-increment subtractor.
package sub_cia_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 0 : width / chunk;
    endfunction

    // Slice-index width: clog2 of the slice count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;
    localparam int unsigned DEF_IDX_W = idx_width(nchunk(DEF_WIDTH, DEF_CHUNK));

endpackage

// File: rtl/chunk_sub_cia.sv
// Combinational CHUNK-bit slice computing x + ~y + cin as a carry-increment adder:
// a carry-free base sum, then a conditional increment by cin.
module chunk_sub_cia #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] base;

    assign base = {1'b0, x} + {1'b0, ~y};
    assign s    = base[CHUNK-1:0] + CHUNK'(cin);
    // The increment carries out only when the base sum is all ones.
    assign cout = base[CHUNK] | (cin & (&base[CHUNK-1:0]));

endmodule

// File: rtl/sub_nbit_cia_seq.sv
// Multi-cycle WIDTH-bit subtractor a - b - bin, one CHUNK-bit slice per clock,
// LSB first, with a registered borrow chain and valid/ready handshakes.
module sub_nbit_cia_seq
    import sub_cia_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK == 0) begin : g_bad_chunk
            $error("sub_nbit_cia_seq: CHUNK must be at least 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("sub_nbit_cia_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             a_msb, b_msb;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             accept, step, last;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;

    // Operand registers shift right each step, so the slice always reads bit 0.
    chunk_sub_cia #(.CHUNK(CHUNK)) u_slice (
        .x    (a_q[CHUNK-1:0]),
        .y    (b_q[CHUNK-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, handshake flags and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                carry <= ~bin;
                idx   <= '0;
            end
            if (step) begin
                a_q   <= a_q >> CHUNK;
                b_q   <= b_q >> CHUNK;
                diff  <= (diff >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
                carry <= slice_cout;
                idx   <= idx + IDX_W'(1);
            end
            if (last) begin
                bout <= ~slice_cout;
                ovf  <= (a_msb != b_msb) && (slice_s[CHUNK-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_sub_nbit_cia_seq.sv
// Scoreboard bench for sub_nbit_cia_seq at WIDTH=16, CHUNK=4: directed corner cases plus random operands.
module tb_sub_nbit_cia_seq;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned N = W / C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    sub_nbit_cia_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the full operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi, input int acc);
        exp_t e;
        int   ud;
        int   sd;
        ud     = int'(x) - int'(y) - int'(bi);
        sd     = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.diff = ud[W-1:0];
        e.bout = (ud < 0);
        e.ovf  = (sd < -32768) || (sd > 32767);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: latency on first valid cycle, stability while held, compare on handshake.
    logic         seen = 1'b0;
    logic [W-1:0] snap_d;
    logic         snap_b;
    logic         snap_o;
    exp_t         got;

    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: diff=0x%0h with no operation pending", diff);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - exp_q[0].acc), N);
                    seen   = 1'b1;
                    snap_d = diff;
                    snap_b = bout;
                    snap_o = ovf;
                end else begin
                    chk("hold_outputs", {14'd0, diff, snap_b, snap_o}, {14'd0, snap_d, bout, ovf});
                end
                if (out_ready) begin
                    got = exp_q.pop_front();
                    chk("diff", 32'(diff), 32'(got.diff));
                    chk("bout", 32'(bout), 32'(got.bout));
                    chk("ovf", 32'(ovf), 32'(got.ovf));
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 1);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input int stall);
        a        = x;
        b        = y;
        bin      = bi;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(x, y, bi, cyc));
        a         = W'($urandom);
        b         = W'($urandom);
        bin       = 1'($urandom);
        out_ready = (stall == 0);
        wait_out_valid();
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_result", 32'(in_ready), 1);
        chk("out_valid_drop", 32'(out_valid), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 1);

        // Directed corner cases
        do_op(16'h1234, 16'h0235, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 1);
        do_op(16'h0005, 16'h0005, 1'b1, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 2);

        // Backpressure with a competing operand set held on the input
        a        = 16'h1111;
        b        = 16'h0101;
        bin      = 1'b0;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk);
        #1;
        exp_q.push_back(model(16'h1111, 16'h0101, 1'b0, cyc));
        out_ready = 1'b0;
        a         = 16'h4321;
        b         = 16'h1234;
        bin       = 1'b1;
        wait_out_valid();
        repeat (5) begin
            chk("bp_in_ready_low", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_rise", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(16'h4321, 16'h1234, 1'b1, cyc));
        out_ready = 1'b1;
        wait_out_valid();
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during the second BUSY cycle aborts the operation
        a        = 16'hABCD;
        b        = 16'h1357;
        bin      = 1'b1;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(16'hABCD, 16'h1357, 1'b1, cyc));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_ready_release", 32'(in_ready), 1);
        do_op(16'h0010, 16'h0001, 1'b0, 0);

        // Random operands with random consumer stalls
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
